// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access controller.
// Checks load/store alignment, builds byte enables and lane-replicated store
// data, and runs a req/ack handshake to a wait-state data memory. While it
// waits, it stalls the pipeline. A completed load's raw word is registered
// together with its byte offset and opcode for the WB-stage extension unit.
// Optional feature: define DM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles without bus_ack. An abort raises bus_err for one cycle.
module dm_access_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_a,
  output logic [2:0]  ld_op,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  // The counter must be able to hold the timeout limit.
  if ((TIMEOUT_CYC >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic        abort;

`ifdef DM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;

  // Abort on the last allowed WAIT cycle; a simultaneous bus_ack wins.
  assign abort = (state == S_WAIT) && !bus_ack && (cnt == CNT_LIM);
`else
  assign abort = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Decode access size, alignment and the lane-aligned store image.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_byte   = 1'b0;
    is_half   = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    if (mem_we) begin
      is_byte = (mem_op == 3'b001);
      is_half = (mem_op == 3'b011);
    end else begin
      is_byte = (mem_op == 3'b001) || (mem_op == 3'b010);
      is_half = (mem_op == 3'b011) || (mem_op == 3'b100);
    end
    is_word    = !is_byte && !is_half;
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    if (mem_we && is_byte) begin
      be_nxt    = 4'b0001 << addr[1:0];
      wdata_nxt = {4{wdata[7:0]}};
    end else if (mem_we && is_half) begin
      be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{wdata[15:0]}};
    end
  end

  // Freeze the pipeline while a request is being accepted or is outstanding.
  // Stall is held low during reset, which abandons any access.
  assign stall = rst_n &&
                 (((state == S_IDLE) && mem_valid && !misaligned) ||
                  ((state == S_WAIT) && !bus_ack && !abort));

  // Handshake FSM with registered bus, load-return and exception outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      op_q      <= '0;
      off_q     <= '0;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      ld_a      <= '0;
      ld_op     <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
`ifdef DM_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      ld_valid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
`ifdef DM_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (mem_valid) begin
            if (misaligned) begin
              exc_adel <= !mem_we;
              exc_ades <= mem_we;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= addr[31:2];
              bus_be    <= be_nxt;
              bus_wdata <= wdata_nxt;
              op_q      <= mem_op;
              off_q     <= addr[1:0];
              state     <= S_WAIT;
`ifdef DM_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= S_IDLE;
            if (!bus_we) begin
              ld_valid <= 1'b1;
              ld_data  <= bus_rdata;
              ld_a     <= off_q;
              ld_op    <= op_q;
            end
          end else if (abort) begin
            bus_req <= 1'b0;
            state   <= S_IDLE;
`ifdef DM_TIMEOUT_EN
            bus_err <= 1'b1;
`endif
          end else begin
`ifdef DM_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench for dm_access_ctrl.
// The stimulus pushes expected bus, load-return and exception events into a
// queue. A negedge monitor pops an entry and compares it whenever the DUT
// presents an event.
module tb_dm_access_ctrl;

`ifdef DM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  mem_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  ld_a;
  logic [2:0]  ld_op;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;

  dm_access_ctrl #(.TIMEOUT_CYC(TB_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .ld_a(ld_a),
    .ld_op(ld_op), .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {K_BUS, K_LD, K_ADEL, K_ADES, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [29:0] waddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] data;
    logic [1:0]  a;
    logic [2:0]  op;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pop the head entry when it is of the expected kind; flag anything else.
  task automatic pop_expect(input kind_e k, input string nm, output exp_t e, output bit ok);
    ok = 1'b0;
    check({"queue_nonempty_", nm}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      check({"event_kind_", nm}, 32'(q[0].kind), 32'(k));
      if (q[0].kind == k) begin
        e  = q.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compare each DUT event against the scoreboard head.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ld_valid) begin
          pop_expect(K_LD, "ld", e, ok);
          if (ok) begin
            check("ld_data", ld_data, e.data);
            check("ld_a", 32'(ld_a), 32'(e.a));
            check("ld_op", 32'(ld_op), 32'(e.op));
          end
        end
        if (exc_adel) pop_expect(K_ADEL, "adel", e, ok);
        if (exc_ades) pop_expect(K_ADES, "ades", e, ok);
        if (bus_err)  pop_expect(K_ERR, "bus_err", e, ok);
        if (bus_req && bus_ack) begin
          pop_expect(K_BUS, "bus", e, ok);
          if (ok) begin
            check("bus_addr", 32'(bus_addr), 32'(e.waddr));
            check("bus_we", 32'(bus_we), 32'(e.we));
            check("bus_be", 32'(bus_be), 32'(e.be));
            if (e.we) check("bus_wdata", bus_wdata, e.wd);
          end
        end
      end
    end
  end

  // One aligned access with wait_n no-ack WAIT cycles before bus_ack.
  task automatic access(input logic we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                        input logic [29:0] x_waddr, input logic [3:0] x_be,
                        input logic [31:0] x_wd, input logic [1:0] x_a, input int x_stall);
    exp_t e;
    int   stall_cnt = 0;
    e.kind = K_BUS; e.waddr = x_waddr; e.we = we; e.be = x_be; e.wd = x_wd;
    e.data = '0; e.a = '0; e.op = '0;
    q.push_back(e);
    if (!we) begin
      e.kind = K_LD; e.data = rd; e.a = x_a; e.op = op;
      q.push_back(e);
    end
    mem_valid = 1'b1; mem_we = we; mem_op = op; addr = a; wdata = wd;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    repeat (wait_n) begin
      @(negedge clk);
      check("req_held", 32'(bus_req), 32'd1);
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b1; bus_rdata = rd;
    @(negedge clk);
    check("req_at_ack", 32'(bus_req), 32'd1);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    bus_ack = 1'b0; mem_valid = 1'b0;
    check("stall_cycles", 32'(stall_cnt), 32'(x_stall));
  endtask

  // One misaligned request: no bus access, no stall, exception pulse follows.
  task automatic bad_access(input logic we, input logic [2:0] op, input logic [31:0] a);
    exp_t e;
    e.kind = we ? K_ADES : K_ADEL; e.waddr = '0; e.we = we; e.be = '0;
    e.wd = '0; e.data = '0; e.a = '0; e.op = '0;
    q.push_back(e);
    mem_valid = 1'b1; mem_we = we; mem_op = op; addr = a; wdata = 32'h1234_5678;
    @(negedge clk);
    check("misalign_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("misalign_no_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_exc", 32'({exc_adel, exc_ades, bus_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sb at 0x1003, two wait cycles.
    access(1'b1, 3'b001, 32'h1003, 32'h0000_00AB, 32'h0, 2, 30'h400, 4'b1000, 32'hABAB_ABAB, 2'd0, 3);
    @(posedge clk); #1;
    // lh at 0x2002, ack in the first request cycle.
    access(1'b0, 3'b100, 32'h2002, 32'h0, 32'h8001_1234, 0, 30'h800, 4'b1111, 32'h0, 2'd2, 1);
    @(posedge clk); #1;
    // Misaligned sw and lhu.
    bad_access(1'b1, 3'b000, 32'h3001);
    bad_access(1'b0, 3'b011, 32'h3001);
    // Back-to-back lw then sh.
    access(1'b0, 3'b000, 32'h0010, 32'h0, 32'hCAFE_F00D, 1, 30'h004, 4'b1111, 32'h0, 2'd0, 2);
    access(1'b1, 3'b011, 32'h0016, 32'h0000_BEEF, 32'h0, 0, 30'h005, 4'b1100, 32'hBEEF_BEEF, 2'd0, 1);
    @(posedge clk); #1;
    // More lanes: sb lane 1, lb at odd byte, sh low half.
    access(1'b1, 3'b001, 32'h1001, 32'h0000_0012, 32'h0, 0, 30'h400, 4'b0010, 32'h1212_1212, 2'd0, 1);
    access(1'b0, 3'b010, 32'h0007, 32'h0, 32'h1122_3344, 3, 30'h001, 4'b1111, 32'h0, 2'd3, 4);
    @(posedge clk); #1;
    access(1'b1, 3'b011, 32'h0020, 32'hFFFF_1234, 32'h0, 1, 30'h008, 4'b0011, 32'h1234_1234, 2'd0, 2);
    @(posedge clk); #1;

    // Reset during WAIT abandons the access immediately.
    mem_valid = 1'b1; mem_we = 1'b0; mem_op = 3'b000; addr = 32'h40;
    @(negedge clk);
    check("pre_rst_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("pre_rst_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_ld_valid", 32'(ld_valid), 32'd0);
    check("mid_rst_ld_data", ld_data, 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h0000, 32'h0, 32'h0000_00F0, 1, 30'h000, 4'b1111, 32'h0, 2'd0, 2);
    @(posedge clk); #1;

`ifdef DM_TIMEOUT_EN
    // No ack: abort in the fourth WAIT cycle.
    begin
      exp_t e;
      e.kind = K_ERR; e.waddr = '0; e.we = 1'b0; e.be = '0;
      e.wd = '0; e.data = '0; e.a = '0; e.op = '0;
      q.push_back(e);
      mem_valid = 1'b1; mem_we = 1'b0; mem_op = 3'b000; addr = 32'h80;
      @(negedge clk);
      check("to_req_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("to_wait_stall", 32'(stall), 32'd1);
        check("to_wait_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("to_abort_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      check("to_req_dropped", 32'(bus_req), 32'd0);
      check("to_ld_data_kept", ld_data, 32'h0000_00F0);
      @(posedge clk); #1;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
